// File: rtl/dcf77_tx_if.sv
// dcf77_tx_if: field load, transmit control and status signals of the DCF77
// frame transmitter. clk/rst stay plain ports on the module.
interface dcf77_tx_if;
  logic       clk_en;
  logic       enable;
  logic       load;
  logic [6:0] minute;
  logic [5:0] hour;
  logic [5:0] day;
  logic [2:0] dow;
  logic [4:0] month;
  logic [7:0] year;
  logic       cest;
  logic       ready;
  logic       tx;
  logic [5:0] sec;
  logic       minute_start;
  logic       underrun;
  logic       load_err;

  modport master (
    output clk_en, enable, load, minute, hour, day, dow, month, year, cest,
    input  ready, tx, sec, minute_start, underrun, load_err
  );

  modport slave (
    input  clk_en, enable, load, minute, hour, day, dow, month, year, cest,
    output ready, tx, sec, minute_start, underrun, load_err
  );
endinterface

// File: rtl/dcf77_tx.sv
// dcf77_tx: DCF77 minute-frame transmitter. BCD fields are packed into a
// 59-bit frame with even parities, double-buffered (pending -> active) and
// sent LSB first as 100 ms / 200 ms pulses, one per second, with second 59
// left empty as the minute mark.
// Optional build macro: DCF77_TX_CHECK_EN (range-check fields on load).
module dcf77_tx #(
  parameter int unsigned PULSE0    = 10,
  parameter int unsigned PULSE1    = 20,
  parameter int unsigned TICKS_SEC = 100
) (
  input  logic       clk,
  input  logic       rst,
  dcf77_tx_if.slave  bus
);

  localparam int unsigned TW = $clog2(TICKS_SEC);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_SEC - 1);

  typedef enum logic [1:0] {S_IDLE, S_GAP, S_SEND} state_t;

  state_t        r_state, w_state_n;
  logic [TW-1:0] r_tick, w_tick_n;
  logic [5:0]    r_sec, w_sec_n;
  logic          r_tx, w_tx_n;
  logic          r_ms, w_ms_n;
  logic          r_ur, w_ur_n;
  logic          w_take;
  logic [TW-1:0] w_plen;

  logic [58:0]   r_pending;
  logic [58:0]   r_active;
  logic          r_pending_valid;
  logic [58:0]   w_frame;

  function automatic logic [58:0] build_frame(
    input logic [6:0] mn, input logic [5:0] hr, input logic [5:0] dy,
    input logic [2:0] dw, input logic [4:0] mo, input logic [7:0] yr,
    input logic cs);
    return {^{yr, mo, dw, dy}, yr, mo, dw, dy, ^hr, hr, ^mn, mn,
            1'b1, 1'b0, ~cs, cs, 16'h0000, 1'b0};
  endfunction

  assign w_frame = build_frame(bus.minute, bus.hour, bus.day, bus.dow,
                               bus.month, bus.year, bus.cest);

`ifdef DCF77_TX_CHECK_EN
  logic r_load_err;
  logic w_fields_ok;

  function automatic logic fields_ok(
    input logic [6:0] mn, input logic [5:0] hr, input logic [5:0] dy,
    input logic [2:0] dw, input logic [4:0] mo, input logic [7:0] yr);
    logic ok;
    ok = (mn[6:4] < 3'd6) && (mn[3:0] < 4'd10);
    ok = ok && (hr[5:4] < 2'd3) && (hr[3:0] < 4'd10)
            && !((hr[5:4] == 2'd2) && (hr[3:0] > 4'd3));
    ok = ok && (dy[3:0] < 4'd10) && !((dy[5:4] == 2'd3) && (dy[3:0] > 4'd1));
    ok = ok && (dw != 3'd0);
    ok = ok && (mo[3:0] < 4'd10) && !(mo[4] && (mo[3:0] > 4'd2));
    ok = ok && (yr[7:4] < 4'd10) && (yr[3:0] < 4'd10);
    return ok;
  endfunction

  assign w_fields_ok  = fields_ok(bus.minute, bus.hour, bus.day, bus.dow,
                                  bus.month, bus.year);
  assign bus.load_err = r_load_err;
`else
  assign bus.load_err = 1'b0;
`endif

  assign bus.ready        = ~r_pending_valid;
  assign bus.tx           = r_tx;
  assign bus.sec          = r_sec;
  assign bus.minute_start = r_ms;
  assign bus.underrun     = r_ur;

  // FSM and counter state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_tick  <= '0;
      r_sec   <= '0;
      r_tx    <= 1'b0;
      r_ms    <= 1'b0;
      r_ur    <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_tick  <= w_tick_n;
      r_sec   <= w_sec_n;
      r_tx    <= w_tx_n;
      r_ms    <= w_ms_n;
      r_ur    <= w_ur_n;
    end
  end

  // Next state, tick/second counters and registered outputs
  always_comb begin
    w_state_n = r_state;
    w_tick_n  = r_tick;
    w_sec_n   = r_sec;
    w_tx_n    = r_tx;
    w_ms_n    = 1'b0;
    w_ur_n    = 1'b0;
    w_take    = 1'b0;
    w_plen    = r_active[r_sec] ? TW'(PULSE1) : TW'(PULSE0);
    if (bus.clk_en) begin
      if (r_state == S_IDLE) begin
        if (bus.enable) begin
          w_state_n = S_GAP;
          w_tick_n  = '0;
          w_sec_n   = 6'd59;
          w_tx_n    = 1'b0;
        end
      end else if (!bus.enable) begin
        w_state_n = S_IDLE;
        w_tick_n  = '0;
        w_sec_n   = '0;
        w_tx_n    = 1'b0;
      end else if (r_tick == TICK_LAST) begin
        // Every wrap into a SEND second starts a pulse at tick 0.
        w_tick_n = '0;
        if (r_state == S_GAP) begin
          if (r_pending_valid) begin
            w_take    = 1'b1;
            w_ms_n    = 1'b1;
            w_state_n = S_SEND;
            w_sec_n   = '0;
            w_tx_n    = 1'b1;
          end else begin
            w_ur_n = 1'b1;
            w_tx_n = 1'b0;
          end
        end else if (r_sec == 6'd58) begin
          w_state_n = S_GAP;
          w_sec_n   = 6'd59;
          w_tx_n    = 1'b0;
        end else begin
          w_sec_n = r_sec + 6'd1;
          w_tx_n  = 1'b1;
        end
      end else begin
        w_tick_n = r_tick + TW'(1);
        w_tx_n   = (r_state == S_SEND) && (w_tick_n < w_plen);
      end
    end
  end

  // Frame buffers: load into pending, hand over to active at the GAP wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending       <= '0;
      r_active        <= '0;
      r_pending_valid <= 1'b0;
`ifdef DCF77_TX_CHECK_EN
      r_load_err      <= 1'b0;
`endif
    end else begin
`ifdef DCF77_TX_CHECK_EN
      r_load_err <= 1'b0;
`endif
      if (w_take) begin
        r_active        <= r_pending;
        r_pending_valid <= 1'b0;
      end else if (bus.load && !r_pending_valid) begin
`ifdef DCF77_TX_CHECK_EN
        if (w_fields_ok) begin
          r_pending       <= w_frame;
          r_pending_valid <= 1'b1;
        end else begin
          r_load_err <= 1'b1;
        end
`else
        r_pending       <= w_frame;
        r_pending_valid <= 1'b1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_dcf77_tx.sv
// tb_dcf77_tx: scoreboard bench for dcf77_tx. Each accepted load pushes the
// expected pulse width of all 60 seconds of its minute; the receiver measures
// every second on tx and pops the matching expectation.
module tb_dcf77_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int exp_q[$];

  dcf77_tx_if bus();

  dcf77_tx #(.PULSE0(10), .PULSE1(20), .TICKS_SEC(100)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // 10 ms tick stand-in: high for one clk out of every two
  initial begin
    bus.clk_en = 1'b0;
    forever begin
      @(negedge clk);
      bus.clk_en = ~bus.clk_en;
    end
  end

  function automatic logic [58:0] tb_frame(
    input logic [6:0] mn, input logic [5:0] hr, input logic [5:0] dy,
    input logic [2:0] dw, input logic [4:0] mo, input logic [7:0] yr,
    input logic cs);
    logic [58:0] f;
    logic p;
    f = '0;
    f[17] = cs;
    f[18] = ~cs;
    f[20] = 1'b1;
    p = 1'b0;
    for (int i = 0; i < 7; i++) begin f[21+i] = mn[i]; p = p ^ mn[i]; end
    f[28] = p;
    p = 1'b0;
    for (int i = 0; i < 6; i++) begin f[29+i] = hr[i]; p = p ^ hr[i]; end
    f[35] = p;
    for (int i = 0; i < 6; i++) f[36+i] = dy[i];
    for (int i = 0; i < 3; i++) f[42+i] = dw[i];
    for (int i = 0; i < 5; i++) f[45+i] = mo[i];
    for (int i = 0; i < 8; i++) f[50+i] = yr[i];
    p = 1'b0;
    for (int i = 36; i < 58; i++) p = p ^ f[i];
    f[58] = p;
    return f;
  endfunction

  task automatic push_frame(input logic [58:0] f);
    for (int i = 0; i < 59; i++) exp_q.push_back(f[i] ? 20 : 10);
    exp_q.push_back(0);
  endtask

  task automatic next_tick();
    do @(posedge clk); while (bus.clk_en !== 1'b1);
    #1;
  endtask

  task automatic do_load(input logic [6:0] mn, input logic [5:0] hr,
                         input logic [5:0] dy, input logic [2:0] dw,
                         input logic [4:0] mo, input logic [7:0] yr,
                         input logic cs);
    bus.minute = mn; bus.hour = hr; bus.day = dy; bus.dow = dw;
    bus.month = mo; bus.year = yr; bus.cest = cs;
    bus.load = 1'b1;
    @(posedge clk);
    #1;
    bus.load = 1'b0;
  endtask

  task automatic wait_minute_start(input int want);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    while (n < 300 && !seen) begin
      next_tick();
      n++;
      if (bus.minute_start === 1'b1) seen = 1'b1;
    end
    n_cmp++;
    if (!seen || n != want) begin
      n_bad++;
      $display("FAIL minute_start_delay: got %0d ticks (seen=%0d) want %0d", n, seen, want);
    end
  endtask

  task automatic recv_seconds(input int first, input int count);
    for (int k = 0; k < count; k++) begin
      int s, w, e;
      s = first + k;
      w = 0;
      e = -1;
      n_cmp++;
      if (bus.sec !== 6'(s)) begin
        n_bad++;
        $display("FAIL sec_index: got %0d want %0d", bus.sec, s);
      end
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL scoreboard_empty: sec %0d has no expectation", s);
      end else begin
        e = exp_q.pop_front();
        n_cmp++;
        if (bus.tx !== (e > 0)) begin
          n_bad++;
          $display("FAIL pulse_start sec %0d: tx=%b want %b", s, bus.tx, (e > 0));
        end
      end
      for (int t = 0; t < 100; t++) begin
        if (bus.tx === 1'b1) w++;
        next_tick();
      end
      if (e >= 0) begin
        n_cmp++;
        if (w != e) begin
          n_bad++;
          $display("FAIL pulse_width sec %0d: got %0d ticks want %0d", s, w, e);
        end
      end
    end
  endtask

  task automatic test_reset();
    bus.enable = 1'b0; bus.load = 1'b0;
    bus.minute = '0; bus.hour = '0; bus.day = '0; bus.dow = '0;
    bus.month = '0; bus.year = '0; bus.cest = 1'b0;
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    n_cmp++;
    if ({bus.ready, bus.tx, bus.sec, bus.minute_start, bus.underrun, bus.load_err} !== 11'b1_0_000000_0_0_0) begin
      n_bad++;
      $display("FAIL reset_state: ready=%b tx=%b sec=%0d ms=%b ur=%b lerr=%b want 1 0 0 0 0 0",
               bus.ready, bus.tx, bus.sec, bus.minute_start, bus.underrun, bus.load_err);
    end
  endtask

  task automatic test_frame();
    do_load(7'h34, 6'h12, 6'h15, 3'd3, 5'h06, 8'h24, 1'b1);
    push_frame(tb_frame(7'h34, 6'h12, 6'h15, 3'd3, 5'h06, 8'h24, 1'b1));
    n_cmp++;
    if (bus.ready !== 1'b0) begin
      n_bad++;
      $display("FAIL ready_after_load: got %b want 0", bus.ready);
    end
    bus.enable = 1'b1;
    next_tick();
    n_cmp++;
    if (bus.sec !== 6'd59 || bus.tx !== 1'b0) begin
      n_bad++;
      $display("FAIL gap_entry: sec=%0d tx=%b want 59 0", bus.sec, bus.tx);
    end
    wait_minute_start(100);
    n_cmp++;
    if (bus.ready !== 1'b1) begin
      n_bad++;
      $display("FAIL ready_after_handover: got %b want 1", bus.ready);
    end
    recv_seconds(0, 60);
  endtask

  task automatic test_underrun_and_ignore();
    int hi;
    n_cmp++;
    if (bus.underrun !== 1'b1 || bus.sec !== 6'd59 || bus.minute_start !== 1'b0) begin
      n_bad++;
      $display("FAIL underrun_pulse: ur=%b sec=%0d ms=%b want 1 59 0", bus.underrun, bus.sec, bus.minute_start);
    end
    hi = 0;
    for (int t = 0; t < 30; t++) begin
      next_tick();
      if (bus.tx !== 1'b0) hi++;
    end
    n_cmp++;
    if (hi != 0) begin
      n_bad++;
      $display("FAIL underrun_tx_quiet: got %0d high ticks want 0", hi);
    end
    do_load(7'h12, 6'h09, 6'h31, 3'd7, 5'h12, 8'h99, 1'b0);
    push_frame(tb_frame(7'h12, 6'h09, 6'h31, 3'd7, 5'h12, 8'h99, 1'b0));
    next_tick();
    do_load(7'h59, 6'h23, 6'h28, 3'd2, 5'h02, 8'h01, 1'b1);
    n_cmp++;
    if (bus.ready !== 1'b0 || bus.load_err !== 1'b0) begin
      n_bad++;
      $display("FAIL ignored_load: ready=%b load_err=%b want 0 0", bus.ready, bus.load_err);
    end
    wait_minute_start(69);
  endtask

  task automatic test_enable_drop();
    n_cmp++;
    if (bus.ready !== 1'b1) begin
      n_bad++;
      $display("FAIL ready_second_handover: got %b want 1", bus.ready);
    end
    do_load(7'h00, 6'h00, 6'h01, 3'd1, 5'h01, 8'h00, 1'b0);
    push_frame(tb_frame(7'h00, 6'h00, 6'h01, 3'd1, 5'h01, 8'h00, 1'b0));
    recv_seconds(0, 30);
    repeat (30) void'(exp_q.pop_front());
    bus.enable = 1'b0;
    next_tick();
    n_cmp++;
    if (bus.tx !== 1'b0 || bus.sec !== 6'd0 || bus.ready !== 1'b0) begin
      n_bad++;
      $display("FAIL disable: tx=%b sec=%0d ready=%b want 0 0 0", bus.tx, bus.sec, bus.ready);
    end
    repeat (5) next_tick();
    bus.enable = 1'b1;
    next_tick();
    n_cmp++;
    if (bus.sec !== 6'd59 || bus.tx !== 1'b0) begin
      n_bad++;
      $display("FAIL reenable_gap: sec=%0d tx=%b want 59 0", bus.sec, bus.tx);
    end
    wait_minute_start(100);
    recv_seconds(0, 60);
  endtask

  task automatic test_load_check();
    bus.enable = 1'b0;
    next_tick();
    n_cmp++;
    if (bus.ready !== 1'b1) begin
      n_bad++;
      $display("FAIL check_ready_idle: got %b want 1", bus.ready);
    end
    do_load(7'h00, 6'h24, 6'h01, 3'd1, 5'h01, 8'h00, 1'b0);
    n_cmp++;
`ifdef DCF77_TX_CHECK_EN
    if (bus.load_err !== 1'b1 || bus.ready !== 1'b1) begin
      n_bad++;
      $display("FAIL hour24_load: load_err=%b ready=%b want 1 1", bus.load_err, bus.ready);
    end
`else
    if (bus.load_err !== 1'b0 || bus.ready !== 1'b0) begin
      n_bad++;
      $display("FAIL hour24_load: load_err=%b ready=%b want 0 0", bus.load_err, bus.ready);
    end
`endif
    next_tick();
    do_load(7'h60, 6'h12, 6'h01, 3'd1, 5'h01, 8'h00, 1'b0);
    n_cmp++;
`ifdef DCF77_TX_CHECK_EN
    if (bus.load_err !== 1'b1 || bus.ready !== 1'b1) begin
      n_bad++;
      $display("FAIL minute60_load: load_err=%b ready=%b want 1 1", bus.load_err, bus.ready);
    end
`else
    if (bus.load_err !== 1'b0 || bus.ready !== 1'b0) begin
      n_bad++;
      $display("FAIL minute60_load: load_err=%b ready=%b want 0 0", bus.load_err, bus.ready);
    end
`endif
  endtask

  task automatic test_mid_reset();
    bus.enable = 1'b1;
    next_tick();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.enable = 1'b0;
    n_cmp++;
    if (bus.ready !== 1'b1 || bus.sec !== 6'd0 || bus.tx !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_reset: ready=%b sec=%0d tx=%b want 1 0 0", bus.ready, bus.sec, bus.tx);
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_underrun_and_ignore();
    test_enable_drop();
    test_load_check();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
